// File: rtl/chip_host_driver_if.sv
// Host-side push/response handshake bundle for chip_host_driver.
interface chip_host_driver_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic [7:0]  rsp_aux;

   modport master (
      output in_valid, in_instr, rsp_ready,
      input  in_ready, rsp_valid, rsp_data, rsp_aux
   );

   modport slave (
      input  in_valid, in_instr, rsp_ready,
      output in_ready, rsp_valid, rsp_data, rsp_aux
   );
endinterface

// File: rtl/chip_host_driver.sv
// Host driver: FIFO-buffered instructions driven onto chip pins, held, then captured as a response.
// Optional transaction counter enabled by defining HOST_DRV_STATS_EN.
module chip_host_driver #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   chip_host_driver_if.slave            host,
   output logic                         chip_ena,
   output logic [7:0]                   chip_ui_in,
   output logic [7:0]                   chip_uio_in,
   input  logic [7:0]                   chip_uo_out,
   input  logic [7:0]                   chip_uio_out,
   input  logic [7:0]                   chip_uio_oe,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic [15:0]                  issued_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

   state_t        state;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [SW-1:0] settle_cnt;
   logic          rsp_valid;
   logic [7:0]    rsp_data;
   logic [7:0]    rsp_aux;
   logic          push_c;
   logic          can_pop_c;
   logic          pop_c;

   // No bypass: a full FIFO refuses pushes even on a popping cycle
   assign push_c    = host.in_valid && (count != CW'(FIFO_DEPTH));
   assign can_pop_c = ena && (count != '0);
   assign pop_c     = can_pop_c && ((state == IDLE) || ((state == RESP) && host.rsp_ready));

   assign host.in_ready  = (count != CW'(FIFO_DEPTH));
   assign host.rsp_valid = rsp_valid;
   assign host.rsp_data  = rsp_data;
   assign host.rsp_aux   = rsp_aux;
   assign chip_ena       = ena;
   assign busy           = (state != IDLE) || (count != '0);
   assign fifo_count     = count;

   // Instruction FIFO storage and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_c) begin
            mem[wr_ptr] <= host.in_instr;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_c) rd_ptr <= rd_ptr + AW'(1);
         if (push_c && !pop_c)      count <= count + CW'(1);
         else if (!push_c && pop_c) count <= count - CW'(1);
      end
   end

   // Issue/settle/capture sequencer; ena low freezes everything except a RESP handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         chip_ui_in  <= '0;
         chip_uio_in <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_aux     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop_c) begin
                  {chip_uio_in, chip_ui_in} <= mem[rd_ptr];
                  settle_cnt                <= SW'(SETTLE_CYCLES - 1);
                  state                     <= SETTLE;
               end
            end
            SETTLE: begin
               if (ena) begin
                  if (settle_cnt == '0) begin
                     rsp_data    <= chip_uo_out;
                     rsp_aux     <= chip_uio_out & chip_uio_oe;
                     rsp_valid   <= 1'b1;
                     chip_ui_in  <= '0;
                     chip_uio_in <= '0;
                     state       <= RESP;
                  end else begin
                     settle_cnt <= settle_cnt - SW'(1);
                  end
               end
            end
            RESP: begin
               if (host.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (pop_c) begin
                     {chip_uio_in, chip_ui_in} <= mem[rd_ptr];
                     settle_cnt                <= SW'(SETTLE_CYCLES - 1);
                     state                     <= SETTLE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HOST_DRV_STATS_EN
   logic [15:0] issued_cnt;

   // Completed-handshake counter, wraps naturally at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             issued_cnt <= '0;
      else if (rsp_valid && host.rsp_ready)  issued_cnt <= issued_cnt + 16'd1;
   end

   assign issued_count = issued_cnt;
`else
   assign issued_count = 16'h0000;
`endif

endmodule

// File: tb/tb_chip_host_driver.sv
// Self-checking bench for chip_host_driver: directed scenarios plus randomized traffic
// checked against a transaction-level queue model and a behavioural chip model.
module tb_chip_host_driver;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        chip_ena;
   logic [7:0]  ui, uio, uo, uio_out, uio_oe;
   logic        busy;
   logic [2:0]  fifo_count;
   logic [15:0] issued_count;
   logic        chip_fn = 1'b0;
   logic [7:0]  k_uo = 8'h00, k_uio = 8'h00, k_oe = 8'h00;

   int          checks = 0, passes = 0, fails = 0;
   int          n, t_last, nr;
   logic        do_push, do_rsp, seen;
   logic [15:0] x;
   logic [15:0] q[$];
   logic [15:0] hs_cnt;

   always #5 clk = ~clk;

   chip_host_driver_if bus ();

   chip_host_driver #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .host         (bus),
      .chip_ena     (chip_ena),
      .chip_ui_in   (ui),
      .chip_uio_in  (uio),
      .chip_uo_out  (uo),
      .chip_uio_out (uio_out),
      .chip_uio_oe  (uio_oe),
      .busy         (busy),
      .fifo_count   (fifo_count),
      .issued_count (issued_count)
   );

   // Chip stand-in: fixed constants, or a simple combinational function of the pins
   always_comb begin
      if (chip_fn) begin
         uo      = ui ^ {uio[3:0], uio[7:4]};
         uio_out = ui + uio;
         uio_oe  = uio ^ 8'h5A;
      end else begin
         uo      = k_uo;
         uio_out = k_uio;
         uio_oe  = k_oe;
      end
   end

   // Response handshakes seen on the bus, for the optional counter
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              hs_cnt <= 16'h0;
      else if (bus.rsp_valid && bus.rsp_ready) hs_cnt <= hs_cnt + 16'h1;
   end

   function automatic logic [15:0] exp_rsp(input logic [15:0] instr);
      logic [7:0] u, v, s;
      u = instr[7:0];
      v = instr[15:8];
      s = u + v;
      return {s & (v ^ 8'h5A), u ^ {v[3:0], v[7:4]}};
   endfunction

   function automatic logic [15:0] exp_issued();
`ifdef HOST_DRV_STATS_EN
      return hs_cnt;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int maxc, output int cyc);
      cyc = 0;
      while (!bus.rsp_valid && cyc < maxc) begin
         step();
         cyc++;
      end
      if (!bus.rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_instr  = 16'h0;
      bus.rsp_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();

      // Reset state
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_ui", ui, 0);
      chk("rst_uio", uio, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_aux", bus.rsp_aux, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_issued", issued_count, 0);
      chk("chip_ena_lo", chip_ena, 0);

      // Single instruction latency and pin hold
      ena   = 1'b1;
      k_uo  = 8'h3C;
      k_uio = 8'hFF;
      k_oe  = 8'h0F;
      chk("chip_ena_hi", chip_ena, 1);
      bus.in_valid = 1'b1;
      bus.in_instr = 16'hA55A;
      step();
      bus.in_valid = 1'b0;
      chk("t1_count", fifo_count, 1);
      chk("t1_ui_e0", ui, 8'h00);
      step();
      chk("t1_ui_e1", ui, 8'h5A);
      chk("t1_uio_e1", uio, 8'hA5);
      chk("t1_vld_e1", bus.rsp_valid, 0);
      step();
      chk("t1_ui_e2", ui, 8'h5A);
      chk("t1_uio_e2", uio, 8'hA5);
      chk("t1_vld_e2", bus.rsp_valid, 0);
      step();
      chk("t1_vld_e3", bus.rsp_valid, 1);
      chk("t1_data", bus.rsp_data, 8'h3C);
      chk("t1_aux", bus.rsp_aux, 8'h0F);
      chk("t1_ui_cleared", ui, 8'h00);
      step();
      chk("t1_vld_hold", bus.rsp_valid, 1);
      chk("t1_data_hold", bus.rsp_data, 8'h3C);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("t1_vld_done", bus.rsp_valid, 0);
      chk("t1_busy_done", busy, 0);
      chk("t1_issued", issued_count, exp_issued());

      // Five pushes into a frozen block: four accepted, then held response
      chip_fn = 1'b1;
      ena = 1'b0;
      q.delete();
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = 16'($urandom);
         if (i == 4) begin
            chk("t2_full_ready", bus.in_ready, 0);
            chk("t2_full_count", fifo_count, 4);
         end else begin
            q.push_back(bus.in_instr);
         end
         step();
      end
      bus.in_valid = 1'b0;
      chk("t2_count_after", fifo_count, 4);
      ena = 1'b1;
      wait_rsp(10, n);
      for (int i = 0; i < 3; i++) begin
         chk("t2_hold_vld", bus.rsp_valid, 1);
         chk("t2_hold_rsp", {bus.rsp_aux, bus.rsp_data}, exp_rsp(q[0]));
         step();
      end
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_rsp(10, n);
         chk("t2_rsp", {bus.rsp_aux, bus.rsp_data}, exp_rsp(q[k]));
         step();
      end
      chk("t2_busy_end", busy, 0);
      chk("t2_issued", issued_count, exp_issued());
      bus.rsp_ready = 1'b0;

      // Back-to-back throughput with rsp_ready high
      ena = 1'b0;
      q.delete();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = 16'($urandom);
         q.push_back(bus.in_instr);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.rsp_ready = 1'b1;
      ena    = 1'b1;
      t_last = -1;
      nr     = 0;
      for (int c = 0; c < 40 && nr < 4; c++) begin
         step();
         if (bus.rsp_valid) begin
            chk("t3_rsp", {bus.rsp_aux, bus.rsp_data}, exp_rsp(q[nr]));
            if (nr > 0) chk("t3_gap", 32'(c - t_last), SETTLE + 1);
            t_last = c;
            nr++;
         end
      end
      chk("t3_nrsp", 32'(nr), 4);
      step();
      chk("t3_busy_end", busy, 0);
      bus.rsp_ready = 1'b0;

      // ena low during SETTLE delays capture by the frozen cycles
      x = 16'($urandom) | 16'h0101;
      bus.in_valid = 1'b1;
      bus.in_instr = x;
      step();
      bus.in_valid = 1'b0;
      step();
      chk("t4_pins_loaded", {uio, ui}, x);
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_pins_frozen", {uio, ui}, x);
         chk("t4_vld_frozen", bus.rsp_valid, 0);
      end
      ena = 1'b1;
      step();
      chk("t4_vld_e7", bus.rsp_valid, 0);
      chk("t4_pins_e7", {uio, ui}, x);
      step();
      chk("t4_vld_e8", bus.rsp_valid, 1);
      chk("t4_rsp", {bus.rsp_aux, bus.rsp_data}, exp_rsp(x));
      ena = 1'b0;
      bus.rsp_ready = 1'b1;
      step();
      chk("t4_hs_with_ena_lo", bus.rsp_valid, 0);
      chk("t4_busy", busy, 0);
      bus.rsp_ready = 1'b0;

      // Asynchronous reset mid-SETTLE with two entries queued
      q.delete();
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = 16'($urandom) | 16'h0001;
         q.push_back(bus.in_instr);
         step();
      end
      bus.in_valid = 1'b0;
      ena = 1'b1;
      step();
      chk("t5_count", fifo_count, 2);
      chk("t5_pins", {uio, ui}, q[0]);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_pins", {uio, ui}, 0);
      chk("t5_rst_count", fifo_count, 0);
      chk("t5_rst_vld", bus.rsp_valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_ready", bus.in_ready, 1);
      chk("t5_rst_issued", issued_count, 0);
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.rsp_valid) seen = 1'b1;
      end
      chk("t5_no_rsp", seen, 0);
      chk("t5_count_after", fifo_count, 0);

      // Randomized traffic against the queue model
      q.delete();
      for (int c = 0; c < 800; c++) begin
         chk("r_busy", busy, (q.size() != 0));
         chk("r_in_ready", bus.in_ready, (fifo_count != 3'(DEPTH)));
         if ({uio, ui} != 16'h0) chk("r_pins", {uio, ui}, (q.size() > 0) ? q[0] : 16'h0);
         if (bus.rsp_valid) begin
            chk("r_rsp_has_txn", (q.size() > 0), 1);
            if (q.size() > 0) chk("r_rsp", {bus.rsp_aux, bus.rsp_data}, exp_rsp(q[0]));
         end
         ena           = ($urandom_range(0, 9) != 0);
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_instr  = 16'($urandom);
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         do_push = bus.in_valid && bus.in_ready;
         do_rsp  = bus.rsp_valid && bus.rsp_ready;
         x       = bus.in_instr;
         step();
         if (do_rsp && q.size() > 0) void'(q.pop_front());
         if (do_push) q.push_back(x);
      end

      // Drain
      ena           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 100 && q.size() > 0; c++) begin
         do_rsp = bus.rsp_valid;
         if (do_rsp) chk("d_rsp", {bus.rsp_aux, bus.rsp_data}, exp_rsp(q[0]));
         step();
         if (do_rsp) void'(q.pop_front());
      end
      chk("d_empty", 32'(q.size()), 0);
      step();
      chk("d_busy", busy, 0);
      chk("d_issued", issued_count, exp_issued());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
